// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start, DATA_W data bits LSB-first,
// optional parity, stop). RX_IN is synchronised through two flops and every
// decision is taken on the synchronised copy. Received bytes appear on P_DATA
// with a one-cycle DATA_VALID pulse; parity and stop errors pulse their flags.
// Optional build macro: UART_RX_MAJORITY_EN selects a 3-sample majority vote
// per bit (decision one tick later); without it a single mid-bit sample is used.
module uart_rx #(
  parameter int PRESCALE = 8,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  output logic [DATA_W-1:0] P_DATA,
  output logic              DATA_VALID,
  output logic              PAR_ERR,
  output logic              STP_ERR,
  output logic              Busy
);

  localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [TW-1:0] TICK_LAST = TW'(PRESCALE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] TICK_DEC  = TW'(PRESCALE / 2);
`else
  localparam logic [TW-1:0] TICK_DEC  = TW'(PRESCALE / 2 - 1);
`endif
  localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              sync1_q, rx_s_q;
  logic [TW-1:0]     tick_q, tick_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d;
  logic              par_typ_q, par_typ_d;
  logic              par_err_q, par_err_d;
  logic [DATA_W-1:0] p_data_q, p_data_d;
  logic              dv_q, dv_d;
  logic              pe_q, pe_d;
  logic              se_q, se_d;
  logic              busy_q, busy_d;
  logic              sample_s;
  logic              bit_s;

  // Two-flop synchroniser on the serial line; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= RX_IN;
      rx_s_q  <= sync1_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote_q, vote_d;

  // Capture the two early samples of the bit; the third is the live line.
  always_comb begin
    vote_d = vote_q;
    if (tick_q == TW'(PRESCALE / 2 - 2)) begin
      vote_d[0] = rx_s_q;
    end else if (tick_q == TW'(PRESCALE / 2 - 1)) begin
      vote_d[1] = rx_s_q;
    end else begin
      vote_d = vote_q;
    end
  end

  // Vote sample register.
  always_ff @(posedge clk) begin
    if (reset) begin
      vote_q <= 2'b11;
    end else begin
      vote_q <= vote_d;
    end
  end

  assign bit_s = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
`else
  assign bit_s = rx_s_q;
`endif

  assign sample_s = (tick_q == TICK_DEC);

  // Next-state and output decode for the frame FSM.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_err_d = par_err_q;
    p_data_d  = p_data_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;

    // Tick counter runs freely across the frame so bit timing stays locked
    // to the falling edge of the start bit.
    if (tick_q == TICK_LAST) begin
      tick_d = TICK_ZERO;
    end else begin
      tick_d = tick_q + TICK_ONE;
    end

    case (state_q)
      IDLE: begin
        tick_d = TICK_ZERO;
        bit_d  = BIT_ZERO;
        if (!rx_s_q) begin
          state_d   = START;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          par_err_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (sample_s) begin
          if (bit_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (sample_s) begin
          shift_d = {bit_s, shift_q[DATA_W-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = BIT_ZERO;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d   = bit_q + BIT_ONE;
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (sample_s) begin
          // Even parity expects ^data, odd expects its inverse.
          par_err_d = bit_s ^ (^shift_q) ^ par_typ_q;
          state_d   = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (sample_s) begin
          state_d = IDLE;
          se_d    = ~bit_s;
          pe_d    = par_err_q;
          if (bit_s && !par_err_q) begin
            dv_d     = 1'b1;
            p_data_d = shift_q;
          end else begin
            dv_d     = 1'b0;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Frame state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tick_q    <= TICK_ZERO;
      bit_q     <= BIT_ZERO;
      shift_q   <= {DATA_W{1'b0}};
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_err_q <= 1'b0;
      p_data_q  <= {DATA_W{1'b0}};
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_err_q <= par_err_d;
      p_data_q  <= p_data_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
      busy_q    <= busy_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = dv_q;
  assign PAR_ERR    = pe_q;
  assign STP_ERR    = se_q;
  assign Busy       = busy_q;

endmodule
